// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine transaction sequencer:
// coin codes and values, product and state encodings, price lookup.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_BAD  = 2'b11
  } coin_e;

  localparam int unsigned COIN_5_VAL  = 5;
  localparam int unsigned COIN_10_VAL = 10;
  // The hopper ejects one $5 coin per handshake.
  localparam int unsigned PAYOUT_UNIT = 5;

  typedef enum logic {
    CHOCO = 1'b0,
    DRINK = 1'b1
  } product_e;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    PAYOUT
  } state_e;

  // Dollar value of a coin code; none/invalid codes are worth nothing.
  function automatic int unsigned coin_value(coin_e c);
    case (c)
      COIN_5:  return COIN_5_VAL;
      COIN_10: return COIN_10_VAL;
      default: return 0;
    endcase
  endfunction

  // Price of a product, given the configured chocolate and drink prices.
  function automatic int unsigned price(product_e p, int unsigned choco, int unsigned drink);
    return (p == DRINK) ? drink : choco;
  endfunction

endpackage

// File: rtl/vm_idle_timer.sv
// Inactivity timer for the CREDIT state.
// Loadable down-counter: i_clear reloads LOAD_VAL, i_en counts down toward 0.
// o_expire is high for a cycle in which the counter sits at 0 while enabled
// and not being cleared.
// Ports:
//   clk       in  clock
//   reset_n   in  asynchronous reset, active-low
//   i_clear   in  reload the counter (activity seen or timer not in use)
//   i_en      in  count enable
//   o_expire  out timeout reached
module vm_idle_timer #(
  parameter int unsigned LOAD_VAL = 999
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= CNT_W'(LOAD_VAL);
    end else if (i_clear) begin
      r_cnt <= CNT_W'(LOAD_VAL);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_en && !i_clear && (r_cnt == '0);

endmodule

// File: rtl/vm_txn_sequencer.sv
// Vending-machine transaction sequencer: accumulates coin credit, checks a
// selection against its price, requests a dispense (vend_req/vend_ack), then
// pays back leftover credit one $5 coin at a time (pay_req/pay_ack).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   coin[1:0]            00 none, 01 $5, 10 $10, 11 invalid
//   select_valid         selection pulse; select_products 0 choco / 1 drink
//   cancel               abort and refund pulse
//   vend_req, vend_prod  dispense request and product, vend_ack completes it
//   pay_req, pay_ack     eject-one-coin request and its completion
//   coin_reject          pulse: coin returned unaccepted
//   short_credit         pulse: selection ignored for insufficient credit
//   credit               current credit in $
//   busy                 high while in VEND or PAYOUT
// All outputs are registered; pulses appear the cycle after their cause.
module vm_txn_sequencer
  import vm_pkg::*;
#(
  parameter int unsigned PRICE_CHOCO = 15,
  parameter int unsigned PRICE_DRINK = 10,
  parameter int unsigned MAX_CREDIT  = 30,
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          coin,
  input  logic                select_valid,
  input  logic                select_products,
  input  logic                cancel,
  output logic                vend_req,
  output logic                vend_prod,
  input  logic                vend_ack,
  output logic                pay_req,
  input  logic                pay_ack,
  output logic                coin_reject,
  output logic                short_credit,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // One extra bit so credit + coin never wraps before the ceiling check.
  localparam int unsigned SUM_W = CREDIT_W + 1;

  if ((PRICE_CHOCO % 5) != 0) begin : g_chk_choco
    $error("PRICE_CHOCO must be a multiple of 5");
  end
  if ((PRICE_DRINK % 5) != 0) begin : g_chk_drink
    $error("PRICE_DRINK must be a multiple of 5");
  end
  if (((2 ** CREDIT_W) - 1) < MAX_CREDIT) begin : g_chk_width
    $error("CREDIT_W too narrow for MAX_CREDIT");
  end
  if (TIMEOUT_CYC < 1) begin : g_chk_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                r_vend_req;
  logic                w_vend_req_nxt;
  logic                r_vend_prod;
  logic                w_vend_prod_nxt;
  logic                r_pay_req;
  logic                w_pay_req_nxt;
  logic                r_coin_reject;
  logic                w_coin_reject_nxt;
  logic                r_short_credit;
  logic                w_short_credit_nxt;
  logic                r_busy;

  logic [SUM_W-1:0]    w_coin_val;
  logic [SUM_W-1:0]    w_coin_sum;
  logic [SUM_W-1:0]    w_credit_acc;
  logic [SUM_W-1:0]    w_price;
  logic [SUM_W-1:0]    w_after_sale;
  logic                w_coin_present;
  logic                w_coin_valid;
  logic                w_coin_ok;
  logic                w_afford;
  logic                w_timer_clear;
  logic                w_timer_en;
  logic                w_timeout;

  assign w_coin_present = (coin != COIN_NONE);
  assign w_coin_valid   = (coin == COIN_5) || (coin == COIN_10);
  assign w_coin_val     = SUM_W'(coin_value(coin_e'(coin)));
  assign w_coin_sum     = {1'b0, r_credit} + w_coin_val;
  assign w_coin_ok      = w_coin_valid && (w_coin_sum <= SUM_W'(MAX_CREDIT));
  // Credit after this cycle's coin, if the coin is accepted.
  assign w_credit_acc   = w_coin_ok ? w_coin_sum : {1'b0, r_credit};

  assign w_price        = SUM_W'(price(product_e'(select_products), PRICE_CHOCO, PRICE_DRINK));
  // Affordability uses the pre-coin credit; a same-cycle coin is added after.
  assign w_afford       = ({1'b0, r_credit} >= w_price);
  assign w_after_sale   = w_credit_acc - w_price;

  assign w_timer_en     = (r_state == CREDIT);
  assign w_timer_clear  = (r_state != CREDIT) || w_coin_present || select_valid;

  vm_idle_timer #(
    .LOAD_VAL(TIMEOUT_CYC - 1)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_timer_clear),
    .i_en    (w_timer_en),
    .o_expire(w_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_vend_req     <= 1'b0;
      r_vend_prod    <= 1'b0;
      r_pay_req      <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_short_credit <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_vend_req     <= w_vend_req_nxt;
      r_vend_prod    <= w_vend_prod_nxt;
      r_pay_req      <= w_pay_req_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
      r_short_credit <= w_short_credit_nxt;
      r_busy         <= (w_state_nxt == VEND) || (w_state_nxt == PAYOUT);
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_vend_req_nxt     = r_vend_req;
    w_vend_prod_nxt    = r_vend_prod;
    w_pay_req_nxt      = 1'b0;
    w_coin_reject_nxt  = 1'b0;
    w_short_credit_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_coin_ok) begin
          w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
          w_state_nxt  = CREDIT;
        end else if (w_coin_present) begin
          w_coin_reject_nxt = 1'b1;
        end
        if (select_valid) begin
          w_short_credit_nxt = 1'b1;
        end
      end

      CREDIT: begin
        // The coin is settled independently of cancel/select/timeout.
        if (w_coin_present && !w_coin_ok) begin
          w_coin_reject_nxt = 1'b1;
        end
        w_credit_nxt = w_credit_acc[CREDIT_W-1:0];
        if (cancel || (!select_valid && w_timeout)) begin
          if (w_credit_acc != '0) begin
            w_state_nxt   = PAYOUT;
            w_pay_req_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (select_valid) begin
          if (w_afford) begin
            w_credit_nxt    = w_after_sale[CREDIT_W-1:0];
            w_vend_req_nxt  = 1'b1;
            w_vend_prod_nxt = select_products;
            w_state_nxt     = VEND;
          end else begin
            w_short_credit_nxt = 1'b1;
          end
        end
      end

      VEND: begin
        w_coin_reject_nxt = w_coin_present;
        if (vend_ack) begin
          w_vend_req_nxt = 1'b0;
          if (r_credit != '0) begin
            w_state_nxt   = PAYOUT;
            w_pay_req_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      PAYOUT: begin
        w_coin_reject_nxt = w_coin_present;
        w_pay_req_nxt     = (r_credit != '0);
        if (r_pay_req && pay_ack) begin
          w_credit_nxt = r_credit - CREDIT_W'(PAYOUT_UNIT);
        end
        // pay_req drops in the same update that brings credit to zero.
        if (w_credit_nxt == '0) begin
          w_pay_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign vend_req     = r_vend_req;
  assign vend_prod    = r_vend_prod;
  assign pay_req      = r_pay_req;
  assign coin_reject  = r_coin_reject;
  assign short_credit = r_short_credit;
  assign credit       = r_credit;
  assign busy         = r_busy;

endmodule
